in5_qualifier: RTL and testbench
================================

// Module: in5_qualifier
// PURPOSE
//  Upstream input-qualification stage for the 5-input NOR primitive with all five inputs inverted (all-high detect).
//  Each of five raw asynchronous inputs passes through a 2-flop synchroniser and a per-bit stability filter.
//  Q[4:0] drives I0..I4 of that gate.
//  A registered all-high flag and one-cycle rise/fall pulses are provided locally, so the downstream gate sees only clean, glitch-free levels.
// PARAMETERS
//  FILT_CYCLES  4        consecutive CE cycles a synchronised mismatch must persist before Q[i] flips (legal 1..15)
//  CNT_W        4        width of each per-bit filter counter; must satisfy 2**CNT_W > FILT_CYCLES
//  INIT         5'b00000 reset value of synchronisers and Q
// PORTS
//  C         in   1  clock, rising edge
//  RN        in   1  reset, synchronous, active-low; sampled on rising C
//  CE        in   1  clock enable for filter, Q, ALL and pulses
//  D         in   5  raw asynchronous inputs, bit i -> Ii
//  Q         out  5  qualified levels, registered
//  ALL       out  1  registered &Q (all five qualified inputs high)
//  ALL_RISE  out  1  one-cycle pulse when ALL goes 0->1
//  ALL_FALL  out  1  one-cycle pulse when ALL goes 1->0
// BEHAVIOUR
//  Reset (RN=0 at rising C) dominates CE:
//   - s1, s2, Q <= INIT; cnt[i] <= 0
//   - ALL <= &INIT; ALL_RISE, ALL_FALL <= 0
//  Synchroniser: s1 <= D; s2 <= s1 every cycle, independent of CE.
//  Filter, per bit i, on each rising C with RN=1 and CE=1:
//   - s2[i]==Q[i]: cnt[i] <= 0 (glitch discarded)
//   - else if cnt[i]==FILT_CYCLES-1: Q[i] <= s2[i]; cnt[i] <= 0
//   - else: cnt[i] <= cnt[i]+1
//   - The five bits filter independently; several bits may flip on the same edge.
//  ALL/pulse stage, on each rising C with RN=1 and CE=1:
//   - ALL <= &Q (value of Q before this edge)
//   - ALL_RISE <= &Q & ~ALL; ALL_FALL <= ~&Q & ALL
//  CE=0: Q, cnt, ALL hold; ALL_RISE and ALL_FALL <= 0; synchroniser still shifts.
//  Latency, CE held high, D stable after being sampled into s1 at edge 0:
//   - Q updates at edge 1+FILT_CYCLES
//   - ALL updates at edge 2+FILT_CYCLES
//   - pulse is high for exactly the cycle after that edge
//  Glitch: a synchronised mismatch lasting fewer than FILT_CYCLES CE cycles never reaches Q; its counter clears.
//  FILT_CYCLES=1: Q[i] follows s2[i] with one cycle delay, with no filtering beyond the synchroniser.
//  Reset mid-filter: partial counts are discarded; Q returns to INIT on the reset edge.
//  Counters never exceed FILT_CYCLES-1; there is no wrap-around.
//  No combinational path from any input to any output.
// TESTING
//  T1 reset: INIT=0, RN=0 one edge, D=5'h1F -> Q=0, ALL=0, pulses 0 on the following cycle.
//  T2 all-high latency: FILT=4, CE=1, D 0->5'h1F sampled at edge 0:
//   - Q=5'h1F at edge 5
//   - ALL=1 and ALL_RISE=1 at edge 6
//   - ALL_RISE=0 at edge 7
//  T3 glitch reject: Q=5'h1F steady, D[2] low for 2 cycles (3 for FILT=4) -> Q, ALL unchanged, no ALL_FALL.
//  T4 sustained drop: from T2 state, D=5'h1B held:
//   - Q=5'h1B 5 edges after D is sampled
//   - ALL_FALL=1 for one cycle on the next edge
//  T5 CE hold: mismatch counted to 2, CE=0 for 10 cycles, CE=1 -> Q flips after 2 more CE cycles; pulses 0 while CE=0.
//  T6 reset mid-filter: cnt=3, RN=0 one edge -> Q=INIT, cnt=0; with D held, the full 1+FILT latency is needed again.

Source files
------------

// File: rtl/in5_qualifier.sv
// rtl/in5_qualifier.sv - synchronise, debounce and all-high detect five async inputs
module in5_qualifier #(
    parameter int         FILT_CYCLES = 4,
    parameter int         CNT_W       = 4,
    parameter logic [4:0] INIT        = 5'b00000
) (
    input  logic       C,
    input  logic       RN,
    input  logic       CE,
    input  logic [4:0] D,
    output logic [4:0] Q,
    output logic       ALL,
    output logic       ALL_RISE,
    output logic       ALL_FALL
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [CNT_W-1:0] cnt [5];

    // Two-flop synchroniser runs every cycle so CE never stretches metastability windows.
    always_ff @(posedge C) begin
        if (!RN) begin
            s1 <= INIT;
            s2 <= INIT;
        end else begin
            s1 <= D;
            s2 <= s1;
        end
    end

    always_ff @(posedge C) begin
        if (!RN) begin
            Q <= INIT;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else if (CE) begin
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == Q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    Q[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Detect stage looks at Q from before this edge, so ALL trails Q by one CE cycle.
    always_ff @(posedge C) begin
        if (!RN) begin
            ALL      <= &INIT;
            ALL_RISE <= 1'b0;
            ALL_FALL <= 1'b0;
        end else if (CE) begin
            ALL      <= &Q;
            ALL_RISE <= (&Q) & ~ALL;
            ALL_FALL <= ~(&Q) & ALL;
        end else begin
            ALL_RISE <= 1'b0;
            ALL_FALL <= 1'b0;
        end
    end

endmodule

// File: tb/tb_in5_qualifier.sv
// tb/tb_in5_qualifier.sv - scoreboard bench for in5_qualifier
module tb_in5_qualifier;

    localparam int FILT = 4;

    logic       C;
    logic       RN;
    logic       CE;
    logic [4:0] D;
    logic [4:0] Q;
    logic       ALL;
    logic       ALL_RISE;
    logic       ALL_FALL;

    in5_qualifier #(
        .FILT_CYCLES(FILT),
        .CNT_W      (4),
        .INIT       (5'b00000)
    ) dut (
        .C        (C),
        .RN       (RN),
        .CE       (CE),
        .D        (D),
        .Q        (Q),
        .ALL      (ALL),
        .ALL_RISE (ALL_RISE),
        .ALL_FALL (ALL_FALL)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] obs;

    logic [4:0] m_s1, m_s2, m_q;
    int         m_cnt [5];
    logic       m_all, m_rise, m_fall;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one rising edge of the qualifier given the inputs held across it.
    task automatic model_edge(input logic [4:0] d, input logic ce, input logic rn);
        if (!rn) begin
            m_s1 = 5'b0; m_s2 = 5'b0; m_q = 5'b0;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_all = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            if (ce) begin
                m_rise = (m_q == 5'h1F) && !m_all;
                m_fall = (m_q != 5'h1F) && m_all;
                m_all  = (m_q == 5'h1F);
                for (int i = 0; i < 5; i++) begin
                    if (m_s2[i] != m_q[i]) begin
                        if (m_cnt[i] + 1 >= FILT) begin
                            m_q[i]   = m_s2[i];
                            m_cnt[i] = 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end else begin
                m_rise = 1'b0;
                m_fall = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
    endtask

    task automatic step(input logic [4:0] d, input logic ce, input logic rn, input string tag);
        logic [7:0] e;
        @(negedge C);
        D  = d;
        CE = ce;
        RN = rn;
        model_edge(d, ce, rn);
        exp_q.push_back({m_q, m_all, m_rise, m_fall});
        @(posedge C);
        #1;
        obs = {Q, ALL, ALL_RISE, ALL_FALL};
        e = exp_q.pop_front();
        chk(tag, obs, e);
    endtask

    initial begin
        D = 5'h00; CE = 1'b1; RN = 1'b0;
        m_s1 = 5'b0; m_s2 = 5'b0; m_q = 5'b0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_all = 1'b0; m_rise = 1'b0; m_fall = 1'b0;

        // T1 reset with all inputs high
        step(5'h1F, 1'b1, 1'b0, "t1_sb");
        chk("t1_reset_out", obs, 8'h00);
        for (int k = 0; k < 4; k++) step(5'h00, 1'b1, 1'b1, "settle_sb");
        chk("t1_idle_out", obs, 8'h00);

        // T2 all-high latency, D sampled into s1 at edge 0
        for (int e = 0; e < 8; e++) begin
            step(5'h1F, 1'b1, 1'b1, "t2_sb");
            if (e == 4) chk("t2_q_e4", obs, 8'h00);
            if (e == 5) chk("t2_q_e5", obs, {5'h1F, 3'b000});
            if (e == 6) chk("t2_all_e6", obs, {5'h1F, 3'b110});
            if (e == 7) chk("t2_rise_e7", obs, {5'h1F, 3'b100});
        end

        // T3 glitch on bit 2 for FILT-1 cycles
        for (int e = 0; e < 3; e++) step(5'h1B, 1'b1, 1'b1, "t3_sb");
        for (int e = 0; e < 8; e++) begin
            step(5'h1F, 1'b1, 1'b1, "t3_sb");
            chk("t3_hold", obs, {5'h1F, 3'b100});
        end

        // T4 sustained drop of bit 2
        for (int e = 0; e < 8; e++) begin
            step(5'h1B, 1'b1, 1'b1, "t4_sb");
            if (e == 4) chk("t4_q_e4", obs, {5'h1F, 3'b100});
            if (e == 5) chk("t4_q_e5", obs, {5'h1B, 3'b100});
            if (e == 6) chk("t4_fall_e6", obs, {5'h1B, 3'b001});
            if (e == 7) chk("t4_fall_e7", obs, {5'h1B, 3'b000});
        end

        // T5 mismatch counted to 2, then CE low for 10 cycles
        for (int e = 0; e < 4; e++) step(5'h1F, 1'b1, 1'b1, "t5_sb");
        for (int e = 0; e < 10; e++) begin
            step(5'h1F, 1'b0, 1'b1, "t5_sb");
            chk("t5_ce_hold", obs, {5'h1B, 3'b000});
        end
        step(5'h1F, 1'b1, 1'b1, "t5_sb");
        chk("t5_ce1", obs, {5'h1B, 3'b000});
        step(5'h1F, 1'b1, 1'b1, "t5_sb");
        chk("t5_ce2_flip", obs, {5'h1F, 3'b000});
        step(5'h1F, 1'b1, 1'b1, "t5_sb");
        chk("t5_rise", obs, {5'h1F, 3'b110});
        step(5'h1F, 1'b1, 1'b1, "t5_sb");

        // T6 reset mid-filter with D held
        for (int e = 0; e < 5; e++) step(5'h1B, 1'b1, 1'b1, "t6_sb");
        chk("t6_pre", obs, {5'h1F, 3'b100});
        step(5'h1B, 1'b1, 1'b0, "t6_sb");
        chk("t6_reset", obs, 8'h00);
        for (int e = 0; e < 7; e++) begin
            step(5'h1B, 1'b1, 1'b1, "t6_sb");
            if (e == 4) chk("t6_q_e4", obs, 8'h00);
            if (e == 5) chk("t6_q_e5", obs, {5'h1B, 3'b000});
        end

        // Random traffic against the reference
        for (int k = 0; k < 400; k++) begin
            logic [4:0] rd;
            logic       rce, rrn;
            rd  = (k % 12 < 9) ? 5'h1F : 5'($urandom_range(0, 31));
            rce = ($urandom_range(0, 7) != 0);
            rrn = ($urandom_range(0, 99) != 0);
            step(rd, rce, rrn, "rand_sb");
        end

        if (exp_q.size() != 0) chk("sb_drain", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
